// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system ID checker.
// Provides the FSM state type, the Avalon word addresses of the system ID
// slave, and the helper that sizes the per-read stall timer.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Timer must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int timer_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Clearable stall counter with an expiry flag for Avalon masters.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear_i      : zero the counter (has priority over stall_i)
//   stall_i      : the current cycle is a stalled read cycle
//   expire_o     : this stalled cycle is the LIMIT-th consecutive one
module sysid_wait_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic stall_i,
  output logic expire_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (stall_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the stalls already seen, so LIMIT-1 plus this one expires.
  assign expire_o = stall_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Boot-time identity checker: sole Avalon-MM master of the system ID slave.
// Reads the ID word (address 0) then the timestamp word (address 1),
// compares both with build-time values, retries on mismatch and gives up
// on a slave that stalls TIMEOUT_CYCLES consecutive cycles.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start             : request a new check (honoured in IDLE or DONE only)
//   m_address, m_read : Avalon read command, decoded from the state register
//   m_waitrequest     : slave stall
//   m_readdata        : slave read data
//   busy, done        : check in progress / check finished
//   id_ok, ts_ok      : last captured words match the expected values
//   timeout_err       : a read stalled too long
//   retry_count       : retries consumed in the current or last check
//   read_id, read_ts  : last captured words
//   dbg_state         : current FSM state
// Handshake: a read transfer completes in a cycle where m_read=1 and
// m_waitrequest=0; while m_waitrequest=1 address and m_read stay unchanged.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1730382123,
  parameter int          MAX_RETRIES    = 3,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [3:0]  retry_count,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output state_t      dbg_state
);

  localparam int         TW    = timer_width(TIMEOUT_CYCLES);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        first_q;
  logic        busy_q, busy_d, done_q, done_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] rid_q, rid_d, rts_q, rts_d;

  logic in_read, stall, expire;

  assign in_read = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign stall   = in_read && m_waitrequest;

  sysid_wait_timer #(
    .WIDTH (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (!stall),
    .stall_i  (stall),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    rid_d   = rid_q;
    rts_d   = rts_q;
    case (state_q)
      ST_IDLE: begin
        // AUTO_START only acts on the first clock after reset release.
        if ((first_q && (AUTO_START != 0)) || start) begin
          state_d = ST_RD_ID;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
          retry_d = '0;
        end
      end
      ST_RD_ID: begin
        if (expire) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!m_waitrequest) begin
          rid_d   = m_readdata;
          state_d = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        if (expire) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!m_waitrequest) begin
          rts_d   = m_readdata;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        id_ok_d = (rid_q == EXPECTED_ID);
        ts_ok_d = (rts_q == EXPECTED_TS);
        if ((id_ok_d && ts_ok_d) || (retry_q == MAX_R)) begin
          state_d = ST_DONE;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RD_ID;
        end
      end
      ST_DONE: begin
        // Captured words are kept so software can still inspect them.
        if (start) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
          retry_d = '0;
          state_d = ST_RD_ID;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      tmo_q   <= 1'b0;
      retry_q <= '0;
      rid_q   <= '0;
      rts_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      rid_q   <= rid_d;
      rts_q   <= rts_d;
    end
  end

  assign m_read      = in_read;
  assign m_address   = (state_q == ST_RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_q;
  assign retry_count = retry_q;
  assign read_id     = rid_q;
  assign read_ts     = rts_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker. Instance A uses the default build (auto start,
// 3 retries, 255-cycle timeout) behind a scripted slave; instance B uses
// AUTO_START=0, MAX_RETRIES=0, TIMEOUT_CYCLES=4 behind a directly driven slave.
module tb_sysid_checker;
  import sysid_checker_pkg::*;

  localparam logic [31:0] A_EXP_ID = 32'd0;
  localparam logic [31:0] A_EXP_TS = 32'd1730382123;
  localparam int          A_MAXR   = 3;
  localparam int          A_TO     = 255;
  localparam logic [31:0] B_EXP_ID = 32'hCAFE_0001;
  localparam logic [31:0] B_EXP_TS = 32'h6000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DUT A ----------------
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic        addr_a, read_a, wait_a, busy_a, done_a, idok_a, tsok_a, to_a;
  logic [31:0] rdata_a, rid_a, rts_a;
  logic [3:0]  rc_a;
  state_t      st_a;

  sysid_checker dut_a (
    .clock(clk), .reset(rst_a), .start(start_a),
    .m_address(addr_a), .m_read(read_a), .m_waitrequest(wait_a), .m_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout_err(to_a),
    .retry_count(rc_a), .read_id(rid_a), .read_ts(rts_a), .dbg_state(st_a)
  );

  // Scripted slave: read number k returns plan_data[k] after plan_stall[k] stalls.
  logic [31:0] plan_data [16];
  int          plan_stall [16];
  logic [3:0]  sl_idx;
  int          sl_cnt;
  int          addr_err = 0;

  assign wait_a  = read_a && (sl_cnt < plan_stall[sl_idx]);
  assign rdata_a = plan_data[sl_idx];

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      sl_idx <= '0;
      sl_cnt <= 0;
    end else if (read_a) begin
      if (wait_a) begin
        sl_cnt <= sl_cnt + 1;
      end else begin
        sl_cnt <= 0;
        sl_idx <= sl_idx + 1'b1;
        if (addr_a !== sl_idx[0]) addr_err <= addr_err + 1;
      end
    end
  end

  // ---------------- DUT B ----------------
  logic        rst_b = 1'b1, start_b = 1'b0, wait_b = 1'b0;
  logic        addr_b, read_b, busy_b, done_b, idok_b, tsok_b, to_b;
  logic [31:0] rdata_b, rid_b, rts_b, b_id, b_ts;
  logic [3:0]  rc_b;
  state_t      st_b;

  assign rdata_b = addr_b ? b_ts : b_id;

  sysid_checker #(
    .EXPECTED_ID(B_EXP_ID), .EXPECTED_TS(B_EXP_TS),
    .MAX_RETRIES(0), .TIMEOUT_CYCLES(4), .AUTO_START(0)
  ) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b),
    .m_address(addr_b), .m_read(read_b), .m_waitrequest(wait_b), .m_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout_err(to_b),
    .retry_count(rc_b), .read_id(rid_b), .read_ts(rts_b), .dbg_state(st_b)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the slave plan pass by pass and work out how the
  // check ends and in which cycle (cycle 1 = first cycle after edge 0).
  typedef struct {
    int          done_cyc;
    int          retries;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] rid;
    logic [31:0] rts;
  } exp_t;

  function automatic exp_t model_a();
    exp_t e;
    int   cyc;
    e = '{done_cyc: 0, retries: 0, id_ok: 1'b0, ts_ok: 1'b0, tmo: 1'b0, rid: 32'd0, rts: 32'd0};
    cyc = 1;
    for (int p = 0; p <= A_MAXR; p++) begin
      if (plan_stall[2*p] >= A_TO) begin
        cyc += A_TO; e.tmo = 1'b1; break;
      end
      cyc += plan_stall[2*p] + 1;
      e.rid = plan_data[2*p];
      if (plan_stall[2*p+1] >= A_TO) begin
        cyc += A_TO; e.tmo = 1'b1; break;
      end
      cyc += plan_stall[2*p+1] + 1;
      e.rts = plan_data[2*p+1];
      cyc += 1;
      e.id_ok = (e.rid == A_EXP_ID);
      e.ts_ok = (e.rts == A_EXP_TS);
      if ((e.id_ok && e.ts_ok) || p == A_MAXR) break;
      e.retries = p + 1;
    end
    e.done_cyc = cyc;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic plan_good();
    for (int i = 0; i < 16; i++) begin
      plan_data[i]  = (i % 2 == 0) ? A_EXP_ID : A_EXP_TS;
      plan_stall[i] = 0;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".m_read"}, read_a, 1'b0);
    chk({tag, ".m_address"}, addr_a, 1'b0);
    chk({tag, ".busy"}, busy_a, 1'b0);
    chk({tag, ".done"}, done_a, 1'b0);
    chk({tag, ".id_ok"}, idok_a, 1'b0);
    chk({tag, ".ts_ok"}, tsok_a, 1'b0);
    chk({tag, ".timeout_err"}, to_a, 1'b0);
    chk({tag, ".retry_count"}, rc_a, 4'd0);
    chk({tag, ".read_id"}, rid_a, 32'd0);
    chk({tag, ".read_ts"}, rts_a, 32'd0);
    chk({tag, ".state"}, 32'(st_a), 32'(ST_IDLE));
  endtask

  // Reset A, release it (auto start) and compare the finished check with the model.
  task automatic run_a(input string tag);
    exp_t e;
    int   cyc;
    e = model_a();
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done_cycle"}, cyc, e.done_cyc);
    chk({tag, ".m_read"}, read_a, 1'b0);
    chk({tag, ".busy"}, busy_a, 1'b0);
    chk({tag, ".id_ok"}, idok_a, e.id_ok);
    chk({tag, ".ts_ok"}, tsok_a, e.ts_ok);
    chk({tag, ".timeout_err"}, to_a, e.tmo);
    chk({tag, ".retry_count"}, rc_a, e.retries);
    chk({tag, ".read_id"}, rid_a, e.rid);
    chk({tag, ".read_ts"}, rts_a, e.rts);
  endtask

  // Wait for B's done from cycle c0, dropping start after the first edge.
  task automatic wait_b_done(input int c0, output int cyc);
    cyc = c0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      cyc++;
    end while (!done_b && cyc < c0 + 50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    int          r;
    int          idle_act;
    logic [31:0] bad_ts;

    plan_good();
    b_id = B_EXP_ID;
    b_ts = B_EXP_TS;
    #2;
    chk_reset_a("por");
    chk("por_b.done", done_b, 1'b0);
    chk("por_b.m_read", read_b, 1'b0);

    // Zero-wait, matching slave: done in cycle 4.
    run_a("auto_ok");

    // Timestamp always wrong: four passes then give up.
    plan_good();
    for (int p = 0; p < 8; p++) plan_data[2*p+1] = 32'h1234_5678;
    run_a("ts_bad");

    // Wrong ID in the first pass only.
    plan_good();
    plan_data[0] = 32'hDEAD_0001;
    run_a("id_retry");

    // Timeout boundary on the timestamp read.
    plan_good();
    plan_stall[1] = A_TO - 1;
    run_a("stall_254");
    plan_good();
    plan_stall[1] = A_TO;
    run_a("stall_255");
    plan_good();
    plan_stall[0] = A_TO;
    run_a("stall_id_255");

    // Reset while stalled in RD_TS after a (wrong) ID was captured.
    plan_good();
    plan_data[0]  = 32'h0BAD_1D00;
    plan_stall[1] = 20;
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    cyc = 0;
    while (!(read_a && addr_a) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrd.reached_rd_ts", read_a && addr_a, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk_reset_a("midrd");
    run_a("after_reset");

    // Randomized plans.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 16; i++) begin
        plan_data[i] = (i % 2 == 0) ? A_EXP_ID : A_EXP_TS;
        if ($urandom_range(0, 2) == 0) plan_data[i] = $urandom;
        r = $urandom_range(0, 9);
        if (r < 6)      plan_stall[i] = $urandom_range(0, 3);
        else if (r < 8) plan_stall[i] = $urandom_range(4, 40);
        else            plan_stall[i] = 246 + r;
      end
      run_a($sformatf("rand%0d", s));
    end
    chk("slave.addr_order", addr_err, 0);

    // ---- Instance B: no auto start ----
    @(negedge clk); rst_b = 1'b0;
    idle_act = 0;
    repeat (6) begin
      @(negedge clk);
      if (read_b || busy_b || done_b) idle_act++;
    end
    chk("b_idle.activity", idle_act, 0);

    bad_ts = B_EXP_TS ^ ($urandom | 32'd1);
    b_ts   = bad_ts;
    @(negedge clk); start_b = 1'b1;                    // cycle 0
    @(negedge clk); start_b = 1'b0;                    // cycle 1
    chk("b_run1.c1_busy", busy_b, 1'b1);
    chk("b_run1.c1_addr", addr_b, 1'b0);
    @(negedge clk); start_b = 1'b1;                    // cycle 2, ignored
    chk("b_run1.c2_addr", addr_b, 1'b1);
    chk("b_run1.c2_read", read_b, 1'b1);
    @(negedge clk);                                    // cycle 3, ignored
    chk("b_run1.c3_state", 32'(st_b), 32'(ST_CHECK));
    chk("b_run1.c3_read", read_b, 1'b0);
    @(negedge clk); start_b = 1'b0;                    // cycle 4
    chk("b_run1.c4_done", done_b, 1'b1);
    chk("b_run1.id_ok", idok_b, 1'b1);
    chk("b_run1.ts_ok", tsok_b, 1'b0);
    chk("b_run1.retry_count", rc_b, 4'd0);
    chk("b_run1.read_ts", rts_b, bad_ts);
    repeat (3) @(negedge clk);
    chk("b_run1.not_queued_done", done_b, 1'b1);
    chk("b_run1.not_queued_busy", busy_b, 1'b0);

    // start in DONE clears status but keeps captured words.
    b_ts = B_EXP_TS;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_run2.c1_busy", busy_b, 1'b1);
    chk("b_run2.c1_done", done_b, 1'b0);
    chk("b_run2.c1_id_ok", idok_b, 1'b0);
    chk("b_run2.c1_read_ts_kept", rts_b, bad_ts);
    wait_b_done(1, cyc);
    chk("b_run2.done_cycle", cyc, 4);
    chk("b_run2.ts_ok", tsok_b, 1'b1);
    chk("b_run2.read_ts", rts_b, B_EXP_TS);

    // ID read stalled for the whole limit: times out in cycle 5.
    @(negedge clk); start_b = 1'b1; wait_b = 1'b1;
    wait_b_done(0, cyc);
    chk("b_tmo.done_cycle", cyc, 5);
    chk("b_tmo.timeout_err", to_b, 1'b1);
    chk("b_tmo.m_read", read_b, 1'b0);
    chk("b_tmo.retry_count", rc_b, 4'd0);
    chk("b_tmo.read_id_kept", rid_b, B_EXP_ID);

    // ID read stalled one cycle short of the limit: completes in cycle 7.
    @(negedge clk); start_b = 1'b1;                    // cycle 0
    @(negedge clk); start_b = 1'b0;                    // cycle 1
    chk("b_s3.c1_timeout_cleared", to_b, 1'b0);
    @(negedge clk);                                    // cycle 2
    @(negedge clk);                                    // cycle 3
    @(negedge clk); wait_b = 1'b0;                     // cycle 4
    wait_b_done(4, cyc);
    chk("b_s3.done_cycle", cyc, 7);
    chk("b_s3.timeout_err", to_b, 1'b0);
    chk("b_s3.id_ok", idok_b, 1'b1);
    chk("b_s3.ts_ok", tsok_b, 1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
